// File: rtl/cpu_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : cpu_bus_responder
// Description : CPU-side bus decoder with work RAM, PPU strobe, pad port and
//               sprite DMA engine that halts the CPU while copying to OAM.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_bus_responder #(
    parameter int RAM_AW = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [7:0]  d_out,
    input  logic        rw,
    output logic [7:0]  d_in,
    output logic        rdy,
    output logic [14:0] prg_addr,
    input  logic [7:0]  prg_data,
    output logic        ppu_cs,
    output logic        ppu_rw,
    output logic [2:0]  ppu_reg,
    output logic [7:0]  ppu_wdata,
    input  logic [7:0]  ppu_rdata,
    output logic        oam_we,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_data,
    input  logic [7:0]  pad_buttons
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ALIGN = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    logic [1:0]        r_state, w_state_next;
    logic [7:0]        r_page, w_page_next;
    logic [7:0]        r_idx, w_idx_next;
    logic [7:0]        r_latch, w_latch_next;
    logic [7:0]        r_d_in;
    logic              r_strobe;
    logic [7:0]        r_shift;
    logic [7:0]        r_ram [0:(1 << RAM_AW) - 1];

    logic              w_sel_ram, w_sel_ppu, w_sel_dma, w_sel_pad, w_sel_prg;
    logic              w_cpu_act, w_cpu_rd, w_cpu_wr;
    logic [RAM_AW-1:0] w_dma_ram_addr;
    logic [7:0]        w_dma_byte;

    assign w_sel_ram = (addr[15:13] == 3'b000);
    assign w_sel_ppu = (addr[15:13] == 3'b001);
    assign w_sel_dma = (addr == 16'h4014);
    assign w_sel_pad = (addr == 16'h4016);
    assign w_sel_prg = addr[15];

    // The CPU bus is only honoured while the CPU is actually running.
    assign w_cpu_act = rdy && !rst;
    assign w_cpu_rd  = w_cpu_act && rw;
    assign w_cpu_wr  = w_cpu_act && !rw;

    assign ppu_cs    = w_cpu_act && w_sel_ppu;
    assign ppu_rw    = rw;
    assign ppu_reg   = addr[2:0];
    assign ppu_wdata = d_out;

    assign w_dma_ram_addr = RAM_AW'({r_page, r_idx});
    assign prg_addr = (r_state == S_READ && r_page[7]) ? {r_page[6:0], r_idx} : addr[14:0];

    always_comb begin
        w_dma_byte = 8'h00;
        if (r_page[7:5] == 3'b000) begin
            w_dma_byte = r_ram[w_dma_ram_addr];
        end else if (r_page[7]) begin
            w_dma_byte = prg_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_page  <= 8'h00;
            r_idx   <= 8'h00;
            r_latch <= 8'h00;
        end else begin
            r_state <= w_state_next;
            r_page  <= w_page_next;
            r_idx   <= w_idx_next;
            r_latch <= w_latch_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_page_next  = r_page;
        w_idx_next   = r_idx;
        w_latch_next = r_latch;
        case (r_state)
            S_IDLE: begin
                if (w_cpu_wr && w_sel_dma) begin
                    w_page_next  = d_out;
                    w_idx_next   = 8'h00;
                    w_state_next = S_ALIGN;
                end
            end
            S_ALIGN: w_state_next = S_READ;
            S_READ: begin
                w_latch_next = w_dma_byte;
                w_state_next = S_WRITE;
            end
            S_WRITE: begin
                w_idx_next   = r_idx + 8'd1;
                w_state_next = (r_idx == 8'hFF) ? S_IDLE : S_READ;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        rdy    = (r_state == S_IDLE);
        oam_we = (r_state == S_WRITE);
    end

    assign oam_addr = r_idx;
    assign oam_data = r_latch;

    // Work RAM deliberately has no reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (w_cpu_wr && w_sel_ram) begin
            r_ram[addr[RAM_AW-1:0]] <= d_out;
        end
    end

    // Unmapped reads fall through and leave the previous value (open bus).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d_in <= 8'h00;
        end else if (w_cpu_rd) begin
            if (w_sel_ram) begin
                r_d_in <= r_ram[addr[RAM_AW-1:0]];
            end else if (w_sel_ppu) begin
                r_d_in <= ppu_rdata;
            end else if (w_sel_pad) begin
                r_d_in <= {7'b0, (r_strobe ? pad_buttons[0] : r_shift[0])};
            end else if (w_sel_prg) begin
                r_d_in <= prg_data;
            end
        end
    end

    assign d_in = r_d_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_strobe <= 1'b0;
            r_shift  <= 8'hFF;
        end else begin
            if (r_strobe) begin
                r_shift <= pad_buttons;
            end else if (w_cpu_rd && w_sel_pad) begin
                r_shift <= {1'b1, r_shift[7:1]};
            end
            if (w_cpu_wr && w_sel_pad) begin
                r_strobe <= d_out[0];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_bus_responder
// Description : Scoreboard bench for cpu_bus_responder (RAM, PPU, pad, DMA, PRG).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_bus_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic [7:0]  d_out;
    logic        rw;
    logic [7:0]  d_in;
    logic        rdy;
    logic [14:0] prg_addr;
    logic [7:0]  prg_data;
    logic        ppu_cs, ppu_rw;
    logic [2:0]  ppu_reg;
    logic [7:0]  ppu_wdata, ppu_rdata;
    logic        oam_we;
    logic [7:0]  oam_addr, oam_data;
    logic [7:0]  pad_buttons;

    cpu_bus_responder #(.RAM_AW(11)) dut (
        .clk(clk), .rst(rst), .addr(addr), .d_out(d_out), .rw(rw),
        .d_in(d_in), .rdy(rdy), .prg_addr(prg_addr), .prg_data(prg_data),
        .ppu_cs(ppu_cs), .ppu_rw(ppu_rw), .ppu_reg(ppu_reg),
        .ppu_wdata(ppu_wdata), .ppu_rdata(ppu_rdata),
        .oam_we(oam_we), .oam_addr(oam_addr), .oam_data(oam_data),
        .pad_buttons(pad_buttons)
    );

    always #5 clk = ~clk;

    // PRG ROM model: byte = low ^ high ^ 0x5A
    assign prg_data = prg_addr[7:0] ^ {1'b0, prg_addr[14:8]} ^ 8'h5A;

    typedef struct {
        int         due;
        logic [7:0] val;
    } rd_exp_t;

    rd_exp_t     rd_q[$];
    logic [15:0] oam_q[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: d_in expectations due on this cycle, and every OAM write pulse.
    always @(negedge clk) begin
        while (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
            if (rd_q[0].due < cyc) chk("d_in_missed", 32'(rd_q[0].due), 32'(cyc));
            else                   chk("d_in", {24'b0, d_in}, {24'b0, rd_q[0].val});
            void'(rd_q.pop_front());
        end
        if (oam_we === 1'b1) begin
            if (oam_q.size() == 0) begin
                chk("oam_unexpected", {16'b0, oam_addr, oam_data}, 32'hFFFF_FFFF);
            end else begin
                chk("oam_write", {16'b0, oam_addr, oam_data}, {16'b0, oam_q[0]});
                void'(oam_q.pop_front());
            end
        end
    end

    task automatic do_op(input logic [15:0] a, input logic r, input logic [7:0] d);
        @(posedge clk);
        #2;
        addr = a; rw = r; d_out = d;
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] exp);
        do_op(a, 1'b1, 8'h00);
        rd_q.push_back('{due: cyc + 1, val: exp});
    endtask

    task automatic idle();
        do_op(16'h5000, 1'b1, 8'h00);
    endtask

    task automatic run_dma(input logic [7:0] page, input string name);
        int low;
        low = 0;
        do_op(16'h4014, 1'b0, page);
        idle();
        for (int k = 0; k < 700; k++) begin
            @(negedge clk);
            if (rdy === 1'b1) break;
            low++;
            if (low == 5) begin
                addr = 16'h0010; rw = 1'b0; d_out = 8'hEE;
            end else if (low == 6) begin
                addr = 16'h2002; rw = 1'b1;
                #1 chk("ppu_cs_during_dma", {31'b0, ppu_cs}, 32'd0);
            end else if (low == 7) begin
                addr = 16'h5000; rw = 1'b1;
            end
        end
        chk({name, "_rdy_low_cycles"}, 32'(low), 32'd513);
        @(negedge clk);
        chk({name, "_oam_drained"}, 32'(oam_q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1; addr = 16'h2000; rw = 1'b1; d_out = 8'h00;
        ppu_rdata = 8'h80; pad_buttons = 8'h81;
        #12;
        chk("rst_d_in", {24'b0, d_in}, 32'h00);
        chk("rst_rdy", {31'b0, rdy}, 32'd1);
        chk("rst_oam", {15'b0, oam_we, oam_addr, oam_data}, 32'd0);
        chk("rst_ppu_cs", {31'b0, ppu_cs}, 32'd0);
        @(posedge clk); #2 rst = 1'b0; addr = 16'h5000;

        // shift register resets to all ones
        rd(16'h4016, 8'h01);
        // RAM mirror
        do_op(16'h0005, 1'b0, 8'h3C);
        rd(16'h0805, 8'h3C);
        do_op(16'h0010, 1'b0, 8'h11);
        // PPU register strobe
        rd(16'h3FFA, 8'h80);
        #1;
        chk("ppu_strobe", {24'b0, ppu_cs, ppu_rw, ppu_reg, 3'b0}, {24'b0, 1'b1, 1'b1, 3'd2, 3'b0});
        do_op(16'h2007, 1'b0, 8'h5C);
        #1;
        chk("ppu_write", {20'b0, ppu_cs, ppu_rw, ppu_reg, ppu_wdata}, {20'b0, 1'b1, 1'b0, 3'd7, 8'h5C});
        // pad: strobe, release, 9 reads
        do_op(16'h4016, 1'b0, 8'h01);
        do_op(16'h4016, 1'b0, 8'h00);
        rd(16'h4016, 8'h01); rd(16'h4016, 8'h00); rd(16'h4016, 8'h00);
        rd(16'h4016, 8'h00); rd(16'h4016, 8'h00); rd(16'h4016, 8'h00);
        rd(16'h4016, 8'h00); rd(16'h4016, 8'h01); rd(16'h4016, 8'h01);

        // DMA from RAM page 2
        for (int i = 0; i < 256; i++) do_op(16'h0200 + 16'(i), 1'b0, 8'(i) ^ 8'hA5);
        for (int i = 0; i < 256; i++) oam_q.push_back({8'(i), 8'(i) ^ 8'hA5});
        run_dma(8'h02, "dma_ram");
        rd(16'h0010, 8'h11);
        idle();

        // reset during DMA at idx 100
        for (int i = 0; i < 256; i++) oam_q.push_back({8'(i), 8'(i) ^ 8'hA5});
        do_op(16'h4014, 1'b0, 8'h02);
        idle();
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 600; k++) begin
                @(negedge clk);
                if (oam_we === 1'b1 && oam_addr == 8'd100) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("dma_reached_idx100", {31'b0, seen}, 32'd1);
        end
        #1 rst = 1'b1;
        #1;
        chk("abort_rdy", {31'b0, rdy}, 32'd1);
        chk("abort_oam_we", {31'b0, oam_we}, 32'd0);
        oam_q.delete();
        @(posedge clk); @(posedge clk); #2 rst = 1'b0;
        rd(16'h0010, 8'h11);
        // restart from PRG page 0x80: byte = idx ^ 0x5A
        for (int i = 0; i < 256; i++) oam_q.push_back({8'(i), 8'(i) ^ 8'h5A});
        run_dma(8'h80, "dma_prg");

        // PRG read then unmapped read keeps d_in
        rd(16'h8123, 8'h78);
        #1 chk("prg_addr", {17'b0, prg_addr}, 32'h0123);
        rd(16'h5000, 8'h78);
        idle(); idle(); idle();
        @(negedge clk);
        chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
